// File: rtl/fcmp_pkg.sv
// Shared types for the floating-point compare arbiter: op encoding and the
// registered request payload carried by the single compare stage.
package fcmp_pkg;

  typedef enum logic [1:0] {
    FEQ  = 2'b00,
    FLT  = 2'b01,
    FLE  = 2'b10,
    RSVD = 2'b11
  } fcmp_op_e;

  // Upper bounds for the per-instance src/tag widths; instances use the low bits.
  localparam int SRC_MAX_W = 2;
  localparam int TAG_MAX_W = 16;

  typedef struct packed {
    fcmp_op_e               op;
    logic [31:0]            x1;
    logic [31:0]            x2;
    logic [SRC_MAX_W-1:0]   src;
    logic [TAG_MAX_W-1:0]   tag;
  } fcmp_req_t;

endpackage

// File: rtl/fcmp_core.sv
// Combinational single-precision compare (feq/flt/fle). Exponent-zero operands
// collapse to zero; NaNs are compared by magnitude like any other value.
module fcmp_core
  import fcmp_pkg::*;
(
  input  fcmp_op_e    op,
  input  logic [31:0] x1,
  input  logic [31:0] x2,
  output logic        flag
);

  logic zero;
  logic sign_diff;
  logic mag_eq;
  logic mag_lt;

  assign zero      = (x1[30:23] == 8'd0) && (x2[30:23] == 8'd0);
  assign sign_diff = x1[31] ^ x2[31];
  assign mag_eq    = (x1[30:0] == x2[30:0]);
  // Same-sign ordering: negative operands reverse the magnitude order.
  assign mag_lt    = x1[31] ? (x2[30:0] < x1[30:0]) : (x1[30:0] < x2[30:0]);

  always_comb begin
    flag = 1'b0;
    case (op)
      FEQ:     flag = zero | (x1 == x2);
      FLT:     flag = zero ? 1'b0 : (sign_diff ? x1[31] : mag_lt);
      FLE:     flag = zero ? 1'b1 : (sign_diff ? x1[31] : (mag_lt | mag_eq));
      default: flag = 1'b0;
    endcase
  end

endmodule

// File: rtl/fcmp_arbiter.sv
// Round-robin arbiter sharing one registered fcmp stage between NREQ requesters,
// followed by a credit-protected output FIFO with valid/ready backpressure.
module fcmp_arbiter
  import fcmp_pkg::*;
#(
  parameter  int NREQ       = 2,
  parameter  int TAG_W      = 4,
  parameter  int OBUF_DEPTH = 4,
  localparam int SRC_W      = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [2*NREQ-1:0]     req_op,
  input  logic [32*NREQ-1:0]    req_x1,
  input  logic [32*NREQ-1:0]    req_x2,
  input  logic [TAG_W*NREQ-1:0] req_tag,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [31:0]           resp_y,
  output logic [SRC_W-1:0]      resp_src,
  output logic [TAG_W-1:0]      resp_tag
);

  localparam int PTR_W = $clog2(OBUF_DEPTH);

  logic [SRC_W-1:0] rr_ptr;
  logic [SRC_W-1:0] grant_idx;
  logic             grant_found;
  logic             space;
  logic             handshake;
  int               idx;

  fcmp_req_t        stage_d;
  fcmp_req_t        stage_q;
  logic             stage_valid;
  logic             stage_flag;

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   fifo_count;
  logic             push;
  logic             pop;
  logic             mem_flag [OBUF_DEPTH];
  logic [SRC_W-1:0] mem_src  [OBUF_DEPTH];
  logic [TAG_W-1:0] mem_tag  [OBUF_DEPTH];

  // First valid requester at or after rr_ptr, wrapping modulo NREQ.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    idx         = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(rr_ptr) + k) % NREQ;
      if (!grant_found && req_valid[idx]) begin
        grant_found = 1'b1;
        grant_idx   = SRC_W'(idx);
      end
    end
  end

  // Credit counts the stage slot too; a same-cycle pop is deliberately ignored
  // so req_ready has no combinational path from resp_ready.
  assign space     = (int'(fifo_count) + int'(stage_valid)) < OBUF_DEPTH;
  assign handshake = rstn && grant_found && space;

  always_comb begin
    req_ready = '0;
    if (handshake) req_ready[grant_idx] = 1'b1;
  end

  always_comb begin
    stage_d     = '0;
    stage_d.op  = fcmp_op_e'(req_op[int'(grant_idx)*2 +: 2]);
    stage_d.x1  = req_x1[int'(grant_idx)*32 +: 32];
    stage_d.x2  = req_x2[int'(grant_idx)*32 +: 32];
    stage_d.src = SRC_MAX_W'(grant_idx);
    stage_d.tag = TAG_MAX_W'(req_tag[int'(grant_idx)*TAG_W +: TAG_W]);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stage_valid <= 1'b0;
      rr_ptr      <= '0;
    end else begin
      stage_valid <= handshake;
      if (handshake)
        rr_ptr <= (grant_idx == SRC_W'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

  // NOTE: payload and FIFO storage are not reset; stage_valid and fifo_count
  // qualify them, and outputs are gated so nothing stale is ever visible.
  always_ff @(posedge clk) begin
    if (handshake) stage_q <= stage_d;
  end

  fcmp_core u_core (
    .op   (stage_q.op),
    .x1   (stage_q.x1),
    .x2   (stage_q.x2),
    .flag (stage_flag)
  );

  assign push = stage_valid;
  assign pop  = resp_valid && resp_ready;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_flag[wr_ptr] <= stage_flag;
      mem_src[wr_ptr]  <= stage_q.src[SRC_W-1:0];
      mem_tag[wr_ptr]  <= stage_q.tag[TAG_W-1:0];
    end
  end

  assign resp_valid = (fifo_count != '0);
  assign resp_y     = {31'd0, resp_valid & mem_flag[rd_ptr]};
  assign resp_src   = resp_valid ? mem_src[rd_ptr] : '0;
  assign resp_tag   = resp_valid ? mem_tag[rd_ptr] : '0;

  // Upper src/tag bits of the shared payload struct are intentionally unused.
  logic unused_stage_bits;
  assign unused_stage_bits = ^{stage_q.src, stage_q.tag};

endmodule

// File: tb/tb_fcmp_arbiter.sv
// Directed bench for fcmp_arbiter: hand-computed compare results, grant order,
// credit limit, latency and async reset, with a response scoreboard.
module tb_fcmp_arbiter;

  localparam int NREQ  = 2;
  localparam int TAG_W = 4;
  localparam int DEPTH = 4;

  logic                  clk = 1'b0;
  logic                  rstn;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [2*NREQ-1:0]     req_op;
  logic [32*NREQ-1:0]    req_x1;
  logic [32*NREQ-1:0]    req_x2;
  logic [TAG_W*NREQ-1:0] req_tag;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [31:0]           resp_y;
  logic [0:0]            resp_src;
  logic [TAG_W-1:0]      resp_tag;

  logic [1:0]       v_op  [NREQ];
  logic [31:0]      v_x1  [NREQ];
  logic [31:0]      v_x2  [NREQ];
  logic [TAG_W-1:0] v_tag [NREQ];
  logic             v_exp [NREQ];

  typedef struct {
    logic [31:0]      y;
    logic [31:0]      src;
    logic [TAG_W-1:0] tag;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   n_pop = 0;

  fcmp_arbiter #(.NREQ(NREQ), .TAG_W(TAG_W), .OBUF_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_x1     (req_x1),
    .req_x2     (req_x2),
    .req_tag    (req_tag),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_y     (resp_y),
    .resp_src   (resp_src),
    .resp_tag   (resp_tag)
  );

  always #5 clk = ~clk;

  always_comb begin
    req_op  = '0;
    req_x1  = '0;
    req_x2  = '0;
    req_tag = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_op[i*2 +: 2]         = v_op[i];
      req_x1[i*32 +: 32]       = v_x1[i];
      req_x2[i*32 +: 32]       = v_x2[i];
      req_tag[i*TAG_W +: TAG_W] = v_tag[i];
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Inputs are stable from posedge+1 to the next posedge, so the negedge view
  // is exactly what the coming edge will act on.
  always @(negedge clk) begin
    if (rstn) begin
      if (resp_valid && resp_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_resp", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("resp_y", resp_y, e.y);
          check("resp_src", 32'(resp_src), e.src);
          check("resp_tag", 32'(resp_tag), 32'(e.tag));
        end
        n_pop++;
      end
      for (int i = 0; i < NREQ; i++) begin
        if (req_valid[i] && req_ready[i])
          sb.push_back('{y: 32'(v_exp[i]), src: 32'(i), tag: v_tag[i]});
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int r, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [TAG_W-1:0] t, input logic e);
    v_op[r]  = op;
    v_x1[r]  = a;
    v_x2[r]  = b;
    v_tag[r] = t;
    v_exp[r] = e;
  endtask

  // Present one request on requester r and hold it until the handshake edge.
  task automatic issue(input int r, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [TAG_W-1:0] t, input logic e);
    set_req(r, op, a, b, t, e);
    req_valid[r] = 1'b1;
    #1;
    for (int k = 0; k < 20 && !req_ready[r]; k++) cyc(1);
    check("issue_accept", 32'(req_ready[r]), 32'd1);
    cyc(1);
    req_valid[r] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int base;
    int acc;
    rstn       = 1'b0;
    resp_ready = 1'b0;
    req_valid  = 2'b11;
    for (int i = 0; i < NREQ; i++) set_req(i, 2'b00, 32'd0, 32'd0, '0, 1'b1);
    #3;
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_resp_y", resp_y, 32'd0);
    check("rst_resp_src", 32'(resp_src), 32'd0);
    check("rst_resp_tag", 32'(resp_tag), 32'd0);
    cyc(1);
    req_valid = '0;
    rstn      = 1'b1;
    cyc(1);

    // Single request: -1.0 < 1.0, visible two edges after the handshake.
    issue(0, 2'b01, 32'hBF80_0000, 32'h3F80_0000, 4'h5, 1'b1);
    check("lat_n1_valid", 32'(resp_valid), 32'd0);
    cyc(1);
    check("lat_n2_valid", 32'(resp_valid), 32'd1);
    check("lat_y", resp_y, 32'd1);
    check("lat_src", 32'(resp_src), 32'd0);
    check("lat_tag", 32'(resp_tag), 32'd5);
    resp_ready = 1'b1;
    cyc(3);

    // Zero, negative, sign-mismatch, denormal and equality cases on req1.
    issue(1, 2'b00, 32'h8000_0000, 32'h0000_0000, 4'h1, 1'b1);
    issue(1, 2'b10, 32'hC000_0000, 32'hC000_0000, 4'h2, 1'b1);
    issue(1, 2'b01, 32'hC000_0000, 32'hBF80_0000, 4'h3, 1'b1);
    issue(1, 2'b01, 32'hBF80_0000, 32'hC000_0000, 4'h4, 1'b0);
    issue(1, 2'b01, 32'h3F80_0000, 32'hBF80_0000, 4'h5, 1'b0);
    issue(1, 2'b00, 32'h0000_0001, 32'h0040_0000, 4'h6, 1'b1);
    issue(1, 2'b01, 32'h0000_0001, 32'h0040_0000, 4'h7, 1'b0);
    issue(1, 2'b10, 32'h3F80_0000, 32'h3F80_0001, 4'h8, 1'b1);
    issue(1, 2'b00, 32'h3F80_0000, 32'h3F80_0001, 4'h9, 1'b0);
    cyc(4);
    check("zero_neg_drained", 32'(sb.size()), 32'd0);

    // Both requesters continuously valid: grants alternate starting at req0.
    base = n_pop;
    set_req(0, 2'b00, 32'h3F80_0000, 32'h3F80_0000, 4'd0, 1'b1);
    set_req(1, 2'b01, 32'h3F80_0000, 32'hBF80_0000, 4'd1, 1'b0);
    req_valid = 2'b11;
    #1;
    for (int c = 0; c < 8; c++) begin
      check("rr_grant", 32'(req_ready), (c % 2 == 0) ? 32'd1 : 32'd2);
      if (c >= 2) check("rr_stream_valid", 32'(resp_valid), 32'd1);
      cyc(1);
      v_tag[c % 2] = TAG_W'(c + 2);
    end
    req_valid = '0;
    cyc(6);
    check("rr_pop_count", 32'(n_pop - base), 32'd8);

    // Backpressure: the stage slot and FIFO together take DEPTH ops.
    resp_ready = 1'b0;
    acc        = 0;
    set_req(0, 2'b10, 32'hC000_0000, 32'hBF80_0000, 4'd8, 1'b1);
    req_valid[0] = 1'b1;
    #1;
    for (int c = 0; c < 10; c++) begin
      if (req_ready[0]) begin
        acc++;
        cyc(1);
        v_tag[0] = TAG_W'(8 + acc);
      end else begin
        cyc(1);
      end
    end
    check("bp_accepted", 32'(acc), 32'(DEPTH));
    check("bp_ready_low", 32'(req_ready), 32'd0);
    check("bp_resp_valid", 32'(resp_valid), 32'd1);
    check("bp_head_tag", 32'(resp_tag), 32'd8);
    req_valid  = '0;
    base       = n_pop;
    resp_ready = 1'b1;
    cyc(8);
    check("bp_drain_count", 32'(n_pop - base), 32'(DEPTH));

    // Reserved op yields 0 but still returns a tagged response.
    issue(0, 2'b11, 32'h3F80_0000, 32'h3F80_0000, 4'hA, 1'b0);
    cyc(4);
    check("rsvd_drained", 32'(sb.size()), 32'd0);

    // Async reset with stage and FIFO occupied; rr_ptr is 1 beforehand.
    resp_ready = 1'b0;
    set_req(0, 2'b00, 32'h4000_0000, 32'h4000_0000, 4'hC, 1'b1);
    req_valid[0] = 1'b1;
    cyc(3);
    set_req(1, 2'b10, 32'h4000_0000, 32'h3F80_0000, 4'hE, 1'b0);
    req_valid = 2'b11;
    #2;
    check("pre_rst_valid", 32'(resp_valid), 32'd1);
    rstn = 1'b0;
    sb.delete();
    #1;
    check("arst_resp_valid", 32'(resp_valid), 32'd0);
    check("arst_req_ready", 32'(req_ready), 32'd0);
    check("arst_resp_tag", 32'(resp_tag), 32'd0);
    cyc(1);
    rstn     = 1'b1;
    v_tag[0] = 4'hD;
    #1;
    check("post_rst_grant", 32'(req_ready), 32'd1);
    cyc(1);
    req_valid  = '0;
    base       = n_pop;
    resp_ready = 1'b1;
    cyc(6);
    check("post_rst_pops", 32'(n_pop - base), 32'd1);
    check("final_sb_empty", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
